sprite_line_fetcher: RTL and testbench

//  Consumer side of the sprite ROM line interface. Accepts one sprite-line request, drives the
//  ROM address/orientation/enable, captures the returned 8-bit active-low line and serialises it

---
 rtl/sprite_line_fetcher.sv | 183 ++++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: requests one 8-pixel line from the sprite ROM and serialises it MSB-first.
// Latency: start in cycle T -> rom_read_en in T+1..T+2, first pixel valid in T+3, done pulse after the last pixel.
// Backpressure: pixel_advance paces the output (each ROM pixel held SCALE advances); start is ignored while busy.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start               - request pulse, only honoured when idle
//   sprite_id/orientation/line_sel - request fields, latched onto rom_* on an accepted start
//   pixel_advance       - pixel-clock enable, only meaningful while serialising
//   rom_data            - combinational ROM response, active low (0 = pixel on)
//   rom_read_en, rom_sprite_id, rom_orient, rom_line - ROM request side
//   pixel_on, pixel_valid - serialised active-high pixel stream
//   busy, done          - not-idle flag and one-cycle end-of-line pulse
//
// Every output is a flop; output next values are derived from the next FSM state
// so nothing combinational reaches the pins.

module sprite_line_fetcher #(
    parameter int SCALE = 1   // advances per ROM pixel, legal 1..8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] sprite_id,
    input  logic [1:0] orientation,
    input  logic [2:0] line_sel,
    input  logic       pixel_advance,
    input  logic [7:0] rom_data,
    output logic       rom_read_en,
    output logic [3:0] rom_sprite_id,
    output logic [1:0] rom_orient,
    output logic [2:0] rom_line,
    output logic       pixel_on,
    output logic       pixel_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        SHIFT   = 2'd3
    } state_t;

    // Repeat counter saturation value; 3 bits covers SCALE up to 8.
    localparam logic [2:0] REP_LAST = 3'(SCALE - 1);

    state_t     state_q, state_d;

    logic [7:0] shreg_q, shreg_d;
    logic [2:0] pix_cnt_q, pix_cnt_d;
    logic [2:0] rep_cnt_q, rep_cnt_d;

    logic [3:0] rom_id_q, rom_id_d;
    logic [1:0] rom_orient_q, rom_orient_d;
    logic [2:0] rom_line_q, rom_line_d;
    logic       rd_en_q, rd_en_d;
    logic       pix_on_q, pix_on_d;
    logic       pix_vld_q, pix_vld_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // An advance that completes the current ROM pixel, and the one that completes the line.
    logic pix_step;
    logic line_end;

    assign pix_step = (state_q == SHIFT) && pixel_advance && (rep_cnt_q == REP_LAST);
    assign line_end = pix_step && (pix_cnt_q == 3'd7);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = SHIFT;
            SHIFT:   if (line_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        shreg_d      = shreg_q;
        pix_cnt_d    = pix_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        rom_id_d     = rom_id_q;
        rom_orient_d = rom_orient_q;
        rom_line_d   = rom_line_q;

        case (state_q)
            IDLE: begin
                // rom_* only change on an accepted request, so they hold between lines.
                if (start) begin
                    rom_id_d     = sprite_id;
                    rom_orient_d = orientation;
                    rom_line_d   = line_sel;
                end
            end
            CAPTURE: begin
                shreg_d   = rom_data;
                pix_cnt_d = 3'd0;
                rep_cnt_d = 3'd0;
            end
            SHIFT: begin
                if (pix_step) begin
                    rep_cnt_d = 3'd0;
                    // Fill with 1 (= pixel off) so stale data never reads as lit.
                    shreg_d   = {shreg_q[6:0], 1'b1};
                    // Wraps to 0 on the line's last pixel, by which time we leave SHIFT.
                    pix_cnt_d = pix_cnt_q + 3'd1;
                end else if (pixel_advance) begin
                    rep_cnt_d = rep_cnt_q + 3'd1;
                end
            end
            default: ;
        endcase

        // Registered outputs look at the state we are about to enter.
        rd_en_d   = (state_d == FETCH) || (state_d == CAPTURE);
        pix_vld_d = (state_d == SHIFT);
        pix_on_d  = (state_d == SHIFT) && !shreg_d[7];
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == SHIFT) && (state_d == IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q      <= 8'hFF;
            pix_cnt_q    <= 3'd0;
            rep_cnt_q    <= 3'd0;
            rom_id_q     <= 4'd0;
            rom_orient_q <= 2'd0;
            rom_line_q   <= 3'd0;
            rd_en_q      <= 1'b0;
            pix_on_q     <= 1'b0;
            pix_vld_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            pix_cnt_q    <= pix_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            rom_id_q     <= rom_id_d;
            rom_orient_q <= rom_orient_d;
            rom_line_q   <= rom_line_d;
            rd_en_q      <= rd_en_d;
            pix_on_q     <= pix_on_d;
            pix_vld_q    <= pix_vld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rom_read_en   = rd_en_q;
    assign rom_sprite_id = rom_id_q;
    assign rom_orient    = rom_orient_q;
    assign rom_line      = rom_line_q;
    assign pixel_on      = pix_on_q;
    assign pixel_valid   = pix_vld_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: one instance at SCALE=1, one at SCALE=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Stimulus is a linear sequence of steps with hand-computed expected pixel patterns.

module tb_sprite_line_fetcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sprite_id;
    logic [1:0] orientation;
    logic [2:0] line_sel;
    logic [7:0] rom_data;

    logic       start_a, adv_a;
    logic       rd_en_a, pix_a, vld_a, busy_a, done_a;
    logic [3:0] rid_a;
    logic [1:0] ror_a;
    logic [2:0] rln_a;

    logic       start_b, adv_b;
    logic       rd_en_b, pix_b, vld_b, busy_b, done_b;
    logic [3:0] rid_b;
    logic [1:0] ror_b;
    logic [2:0] rln_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_line_fetcher #(.SCALE(1)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .sprite_id(sprite_id),
        .orientation(orientation), .line_sel(line_sel), .pixel_advance(adv_a),
        .rom_data(rom_data), .rom_read_en(rd_en_a), .rom_sprite_id(rid_a),
        .rom_orient(ror_a), .rom_line(rln_a), .pixel_on(pix_a),
        .pixel_valid(vld_a), .busy(busy_a), .done(done_a)
    );

    sprite_line_fetcher #(.SCALE(2)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .sprite_id(sprite_id),
        .orientation(orientation), .line_sel(line_sel), .pixel_advance(adv_b),
        .rom_data(rom_data), .rom_read_en(rd_en_b), .rom_sprite_id(rid_b),
        .rom_orient(ror_b), .rom_line(rln_b), .pixel_on(pix_b),
        .pixel_valid(vld_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the 8 SHIFT cycles of instance A (advance every cycle). exp bit 7 is the first pixel.
    // start_a is pulsed during pixel index pulse_at to show it is ignored.
    task automatic shift_a(input logic [7:0] exp, input int pulse_at);
        for (int k = 0; k < 8; k++) begin
            chk("a_valid", {31'd0, vld_a}, 32'd1);
            chk("a_pixel", {31'd0, pix_a}, {31'd0, exp[7-k]});
            chk("a_rden_off", {31'd0, rd_en_a}, 32'd0);
            start_a = (k == pulse_at);
            tick();
        end
        start_a = 1'b0;
        chk("a_done", {31'd0, done_a}, 32'd1);
        chk("a_busy_end", {31'd0, busy_a}, 32'd0);
        chk("a_valid_end", {31'd0, vld_a}, 32'd0);
        chk("a_pixel_end", {31'd0, pix_a}, 32'd0);
    endtask

    // Walk instance B through 32 SHIFT cycles with an advance on every 2nd cycle:
    // each pixel is held for 4 cycles and the 16th advance ends the line.
    task automatic shift_b(input logic [7:0] exp);
        for (int j = 0; j < 32; j++) begin
            chk("b_valid", {31'd0, vld_b}, 32'd1);
            chk("b_pixel", {31'd0, pix_b}, {31'd0, exp[7 - (j / 4)]});
            chk("b_done_early", {31'd0, done_b}, 32'd0);
            adv_b = (j % 2 == 1);
            tick();
        end
        adv_b = 1'b0;
        chk("b_done", {31'd0, done_b}, 32'd1);
        chk("b_valid_end", {31'd0, vld_b}, 32'd0);
        chk("b_busy_end", {31'd0, busy_b}, 32'd0);
        tick();
        chk("b_done_once", {31'd0, done_b}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_pix;

        reset = 1'b1;
        start_a = 1'b0; adv_a = 1'b0;
        start_b = 1'b0; adv_b = 1'b0;
        sprite_id = 4'd0; orientation = 2'd0; line_sel = 3'd0; rom_data = 8'hFF;
        tick();
        tick();
        chk("rst_rden", {31'd0, rd_en_a}, 32'd0);
        chk("rst_rom", {23'd0, rid_a, ror_a, rln_a}, 32'd0);
        chk("rst_out", {28'd0, pix_a, vld_a, busy_a, done_a}, 32'd0);
        chk("rst_out_b", {28'd0, pix_b, vld_b, busy_b, done_b}, 32'd0);
        reset = 1'b0;
        tick();

        // ---- A: id 0 UP line 1, ROM 10011001, SCALE 1 ----
        sprite_id = 4'd0; orientation = 2'd0; line_sel = 3'd1; rom_data = 8'b10011001;
        adv_a = 1'b1;
        start_a = 1'b1;                      // cycle T
        chk("a_rden_T", {31'd0, rd_en_a}, 32'd0);
        tick();                              // T+1 FETCH
        start_a = 1'b0;
        chk("a_rden_T1", {31'd0, rd_en_a}, 32'd1);
        chk("a_busy_T1", {31'd0, busy_a}, 32'd1);
        chk("a_valid_T1", {31'd0, vld_a}, 32'd0);
        chk("a_rom_T1", {23'd0, rid_a, ror_a, rln_a}, {23'd0, 4'd0, 2'd0, 3'd1});
        // start during FETCH with different fields: must be ignored
        sprite_id = 4'd5; line_sel = 3'd7; start_a = 1'b1;
        tick();                              // T+2 CAPTURE
        start_a = 1'b0;
        chk("a_rden_T2", {31'd0, rd_en_a}, 32'd1);
        chk("a_valid_T2", {31'd0, vld_a}, 32'd0);
        chk("a_rom_T2", {23'd0, rid_a, ror_a, rln_a}, {23'd0, 4'd0, 2'd0, 3'd1});
        tick();                              // T+3 first pixel
        exp_pix = 8'b01100110;
        shift_a(exp_pix, 3);                 // ends in cycle T+11 with done
        chk("a_rom_after", {23'd0, rid_a, ror_a, rln_a}, {23'd0, 4'd0, 2'd0, 3'd1});

        // ---- start on the done cycle: id 9 (blank), orient 3, line 5 ----
        sprite_id = 4'd9; orientation = 2'd3; line_sel = 3'd5; rom_data = 8'hFF;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a2_done_clear", {31'd0, done_a}, 32'd0);
        chk("a2_rden_T1", {31'd0, rd_en_a}, 32'd1);
        chk("a2_busy_T1", {31'd0, busy_a}, 32'd1);
        chk("a2_rom_T1", {23'd0, rid_a, ror_a, rln_a}, {23'd0, 4'd9, 2'd3, 3'd5});
        orientation = 2'd0; line_sel = 3'd0;
        tick();
        chk("a2_rden_T2", {31'd0, rd_en_a}, 32'd1);
        chk("a2_rom_T2", {23'd0, rid_a, ror_a, rln_a}, {23'd0, 4'd9, 2'd3, 3'd5});
        tick();
        exp_pix = 8'h00;
        shift_a(exp_pix, -1);
        tick();
        chk("a2_done_once", {31'd0, done_a}, 32'd0);
        chk("a2_rom_held", {23'd0, rid_a, ror_a, rln_a}, {23'd0, 4'd9, 2'd3, 3'd5});
        adv_a = 1'b0;

        // ---- B: id 1 line 6, ROM 11000111, SCALE 2 ----
        sprite_id = 4'd1; orientation = 2'd0; line_sel = 3'd6; rom_data = 8'b11000111;
        adv_b = 1'b1;                        // advances outside SHIFT must be ignored
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_rden_T1", {31'd0, rd_en_b}, 32'd1);
        chk("b_rom_T1", {23'd0, rid_b, ror_b, rln_b}, {23'd0, 4'd1, 2'd0, 3'd6});
        tick();
        chk("b_rden_T2", {31'd0, rd_en_b}, 32'd1);
        adv_b = 1'b0;
        tick();
        exp_pix = 8'b00111000;
        shift_b(exp_pix);

        // ---- reset in the middle of SHIFT ----
        sprite_id = 4'd4; orientation = 2'd2; line_sel = 3'd2; rom_data = 8'h00;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        tick();
        chk("r_valid_pre", {31'd0, vld_b}, 32'd1);
        chk("r_pixel_pre", {31'd0, pix_b}, 32'd1);
        adv_b = 1'b1;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("r_async_out", {28'd0, pix_b, vld_b, busy_b, done_b}, 32'd0);
        chk("r_async_rom", {23'd0, rid_b, ror_b, rln_b}, 32'd0);
        chk("r_async_rden", {31'd0, rd_en_b}, 32'd0);
        adv_b = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("r_no_done", {31'd0, done_b}, 32'd0);
        tick();
        chk("r_no_done2", {28'd0, pix_b, vld_b, busy_b, done_b}, 32'd0);

        // ---- normal request after reset: id 2 RIGHT line 3, ROM 7F ----
        sprite_id = 4'd2; orientation = 2'd1; line_sel = 3'd3; rom_data = 8'h7F;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("p_rden_T1", {31'd0, rd_en_b}, 32'd1);
        chk("p_rom_T1", {23'd0, rid_b, ror_b, rln_b}, {23'd0, 4'd2, 2'd1, 3'd3});
        tick();
        tick();
        chk("p_rden_T3", {31'd0, rd_en_b}, 32'd0);
        exp_pix = 8'b10000000;
        shift_b(exp_pix);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
